// File: rtl/i2s_sample_tx_if.sv
// Sample-pair valid/ready handshake between a PCM source and the I2S transmitter.
interface i2s_sample_tx_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic                    sample_valid;
    logic [SAMPLE_WIDTH-1:0] sample_left;
    logic [SAMPLE_WIDTH-1:0] sample_right;
    logic                    sample_ready;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/i2s_sample_tx.sv
// Philips-I2S serialiser: one left/right pair per frame, one-entry holding register,
// bclk/lrclk derived from clk by an integer divider.
module i2s_sample_tx #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH   = 16,
    parameter int unsigned CLK_DIV      = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    i2s_sample_tx_if.slave   smp,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);
    localparam int unsigned FRAME_W = 2 * SLOT_WIDTH;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(FRAME_W - 2);

    logic                    hold_full;
    logic [SAMPLE_WIDTH-1:0] hold_left;
    logic [SAMPLE_WIDTH-1:0] hold_right;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_W-1:0]      shifter;

    logic                    xfer_c;
    logic                    div_tc_c;
    logic                    fall_c;
    logic                    load_c;
    logic [BIT_W-1:0]        bit_nxt_c;
    logic [FRAME_W-1:0]      frame_c;

    assign smp.sample_ready = ~hold_full;
    assign xfer_c    = smp.sample_valid & ~hold_full;
    assign div_tc_c  = (div_cnt == DIV_LAST);
    assign fall_c    = enable & div_tc_c & bclk;
    assign load_c    = fall_c & (bit_cnt == BIT_LAST);
    assign bit_nxt_c = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

    // Frame word: held pair, else a same-clk bypass pair, else silence.
    always_comb begin
        frame_c = '0;
        if (hold_full) begin
            frame_c[FRAME_W-1    -: SAMPLE_WIDTH] = hold_left;
            frame_c[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_right;
        end else if (xfer_c) begin
            frame_c[FRAME_W-1    -: SAMPLE_WIDTH] = smp.sample_left;
            frame_c[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = smp.sample_right;
        end
    end

    // Holding register survives enable drops; a frame load always empties it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (load_c) begin
            hold_full  <= 1'b0;
        end else if (xfer_c) begin
            hold_full  <= 1'b1;
            hold_left  <= smp.sample_left;
            hold_right <= smp.sample_right;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt  <= '0;
            bit_cnt  <= BIT_LAST;
            shifter  <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else if (!enable) begin
            div_cnt  <= '0;
            bit_cnt  <= BIT_LAST;
            shifter  <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (div_tc_c) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // All serial state moves on the bclk falling edge.
            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrclk   <= (bit_nxt_c >= LR_LO) && (bit_nxt_c <= LR_HI);
                if (load_c) begin
                    sdata    <= frame_c[FRAME_W-1];
                    shifter  <= {frame_c[FRAME_W-2:0], 1'b0};
                    underrun <= ~hold_full & ~xfer_c;
                end else begin
                    sdata    <= shifter[FRAME_W-1];
                    shifter  <= {shifter[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: time-based reference of the I2S waveform plus a
// pair-level model of the holding register, checked every clk.
module tb_i2s_sample_tx;
    localparam int S = 16;
    localparam int D = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic en   = 1'b0;
    logic pen  = 1'b0;
    logic bclk, lrclk, sdata, underrun;
    logic p_bclk, p_lrclk, p_sdata, p_underrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: enabled-clk count, pair currently on the wire, holding slot.
    int          en_t   = 0;
    bit          m_full = 1'b0;
    bit          m_und  = 1'b0;
    bit          m_xfer = 1'b0;
    bit          m_load = 1'b0;
    logic [15:0] h_l    = '0;
    logic [15:0] h_r    = '0;
    logic [31:0] cur    = '0;
    logic [31:0] rx_sh  = '0;
    logic [31:0] rx_q[$];
    logic [31:0] sent_q[$];

    always #5 clk = ~clk;

    i2s_sample_tx_if #(.SAMPLE_WIDTH(16)) bus ();
    i2s_sample_tx_if #(.SAMPLE_WIDTH(16)) pbus ();

    i2s_sample_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(S), .CLK_DIV(D)) dut (
        .clk(clk), .rstn(rstn), .enable(en), .smp(bus.slave),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    i2s_sample_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24), .CLK_DIV(D)) u_pad (
        .clk(clk), .rstn(rstn), .enable(pen), .smp(pbus.slave),
        .bclk(p_bclk), .lrclk(p_lrclk), .sdata(p_sdata), .underrun(p_underrun)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame loads land on every 2*S-th bclk falling edge, the first one at 2*D clks.
    function automatic bit is_load(input int t);
        return (t % (2 * D) == 0) && (((t / (2 * D)) - 1) % (2 * S) == 0);
    endfunction

    function automatic bit nxt_load();
        return en && is_load(en_t + 1);
    endfunction

    task automatic check_link();
        int f;
        int b;
        bit e_b, e_lr, e_sd;
        e_b = 1'b0; e_lr = 1'b0; e_sd = 1'b0;
        if (en_t > 0) begin
            e_b = 1'((en_t / D) % 2);
            f = en_t / (2 * D);
            if (f > 0) begin
                b    = (f - 1) % (2 * S);
                e_sd = cur[2 * S - 1 - b];
                e_lr = (b >= S - 1) && (b <= 2 * S - 2);
            end
        end
        chk("bclk",     48'(bclk),             48'(e_b));
        chk("lrclk",    48'(lrclk),            48'(e_lr));
        chk("sdata",    48'(sdata),            48'(e_sd));
        chk("underrun", 48'(underrun),         48'(m_und));
        chk("ready",    48'(bus.sample_ready), 48'(!m_full));
        // Receiver view: sample sdata on each bclk rising edge, push whole frames.
        if (en_t > 0 && en_t % (2 * D) == D && en_t / (2 * D) > 0) begin
            rx_sh = {rx_sh[30:0], sdata};
            if (((en_t / (2 * D)) - 1) % (2 * S) == 2 * S - 1) rx_q.push_back(rx_sh);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_und = 1'b0; m_xfer = 1'b0; m_load = 1'b0;
        if (!rstn) begin
            m_full = 1'b0;
            en_t   = 0;
        end else begin
            m_xfer = bus.sample_valid && !m_full;
            if (en) begin
                en_t++;
                m_load = is_load(en_t);
            end else begin
                en_t = 0;
            end
            if (m_load) begin
                if (m_full) begin
                    cur    = {h_l, h_r};
                    m_full = 1'b0;
                end else if (m_xfer) begin
                    cur = {bus.sample_left, bus.sample_right};
                end else begin
                    cur   = '0;
                    m_und = 1'b1;
                end
                sent_q.push_back(cur);
            end else if (m_xfer) begin
                m_full = 1'b1;
                h_l    = bus.sample_left;
                h_r    = bus.sample_right;
            end
        end
        #1;
        check_link();
    endtask

    task automatic do_reset();
        en = 1'b0; pen = 1'b0;
        bus.sample_valid = 1'b0; pbus.sample_valid = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        rx_q.delete(); sent_q.delete();
    endtask

    initial begin
        logic [47:0] pw;
        logic [31:0] pq[3];
        int          und_t;
        int          idx;
        int          w;
        int          ut[$];
        int          acc[$];

        bus.sample_valid = 1'b0;  bus.sample_left = '0;  bus.sample_right = '0;
        pbus.sample_valid = 1'b0; pbus.sample_left = '0; pbus.sample_right = '0;

        // Asynchronous reset values before any clk edge.
        #1 rstn = 1'b0;
        #1;
        chk("rst_bclk",  48'(bclk),             48'd0);
        chk("rst_lrclk", 48'(lrclk),            48'd0);
        chk("rst_sdata", 48'(sdata),            48'd0);
        chk("rst_und",   48'(underrun),         48'd0);
        chk("rst_ready", 48'(bus.sample_ready), 48'd1);
        do_reset();

        // Padding: 24-bit slots carry 16 sample bits then 8 zeros; frame 192 clk.
        pbus.sample_valid = 1'b1; pbus.sample_left = 16'hFFFF; pbus.sample_right = 16'h1234;
        tick();
        pbus.sample_valid = 1'b0;
        pen = 1'b1;
        pw = 48'hFFFF00_123400;
        und_t = -1;
        for (int t = 1; t <= 400; t++) begin
            tick();
            if (p_underrun === 1'b1 && und_t < 0) und_t = t;
            if (t >= 6 && (t - 6) % 4 == 0 && (t - 6) / 4 < 48) begin
                idx = (t - 6) / 4;
                chk("pad_bit",   48'(p_sdata), 48'(pw[47 - idx]));
                chk("pad_bclk",  48'(p_bclk),  48'd1);
                chk("pad_lrclk", 48'(p_lrclk), 48'((idx >= 23) && (idx <= 46)));
            end
        end
        chk("pad_frame_len", 48'(und_t), 48'd196);
        pen = 1'b0;

        // Basic frame: pair held before the first load goes out MSB first.
        do_reset();
        bus.sample_valid = 1'b1; bus.sample_left = 16'hA5F0; bus.sample_right = 16'h0F0F;
        en = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        repeat (140) tick();
        chk("basic_nrx", 48'(rx_q.size()), 48'd1);
        if (rx_q.size() > 0) chk("basic_word", 48'(rx_q[0]), 48'h0000_A5F0_0F0F);

        // Underrun: no source at all, one pulse per 128 clk.
        do_reset();
        en = 1'b1;
        repeat (300) begin
            tick();
            if (underrun === 1'b1) ut.push_back(en_t);
        end
        chk("und_count", 48'(ut.size()), 48'd3);
        for (int i = 1; i < ut.size(); i++) chk("und_period", 48'(ut[i] - ut[i - 1]), 48'd128);

        // Backpressure: three pairs offered back to back.
        do_reset();
        for (int i = 0; i < 3; i++) pq[i] = $urandom;
        idx = 0;
        bus.sample_valid = 1'b1; {bus.sample_left, bus.sample_right} = pq[0];
        en = 1'b1;
        repeat (532) begin
            tick();
            if (m_xfer) begin
                acc.push_back(en_t);
                idx++;
                if (idx < 3) {bus.sample_left, bus.sample_right} = pq[idx];
                else bus.sample_valid = 1'b0;
            end
        end
        chk("bp_nacc", 48'(acc.size()), 48'd3);
        if (acc.size() == 3) begin
            chk("bp_acc1", 48'(acc[0]), 48'd1);
            chk("bp_acc2", 48'(acc[1]), 48'd5);
            chk("bp_acc3", 48'(acc[2]), 48'd133);
        end
        chk("bp_nrx", 48'(rx_q.size()), 48'd4);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) chk("bp_word", 48'(rx_q[i]), 48'(pq[i]));

        // Bypass: pair offered exactly on the load clk with the holding slot empty.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 20 && !nxt_load(); k++) tick();
        bus.sample_valid = 1'b1; bus.sample_left = 16'h8001; bus.sample_right = 16'h7FFE;
        tick();
        bus.sample_valid = 1'b0;
        chk("byp_und", 48'(underrun), 48'd0);
        tick();
        chk("byp_ready", 48'(bus.sample_ready), 48'd1);
        repeat (130) tick();
        chk("byp_nrx", 48'(rx_q.size() >= 1), 48'd1);
        if (rx_q.size() > 0) chk("byp_word", 48'(rx_q[0]), 48'h0000_8001_7FFE);

        // Random traffic, sparse enough to mix held, bypass and underrun frames.
        do_reset();
        en = 1'b1;
        repeat (8 * 128) begin
            if (!bus.sample_valid || m_xfer) begin
                bus.sample_valid = ($urandom % 64) == 0;
                bus.sample_left  = 16'($urandom);
                bus.sample_right = 16'($urandom);
            end
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("rnd_nrx", 48'(rx_q.size() >= 7), 48'd1);
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk("rnd_word", 48'(rx_q[i]), 48'(sent_q[i]));

        // Async reset mid-frame with a pair waiting: everything clears, slot empties.
        do_reset();
        bus.sample_valid = 1'b1; {bus.sample_left, bus.sample_right} = 32'hFC00_FFFF;
        en = 1'b1;
        tick();
        {bus.sample_left, bus.sample_right} = 32'h1357_9BDF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_xfer) break;
        end
        bus.sample_valid = 1'b0;
        for (int k = 0; k < 40 && en_t < 26; k++) tick();
        chk("pre_rst_bclk",  48'(bclk),  48'd1);
        chk("pre_rst_sdata", 48'(sdata), 48'd1);
        rstn = 1'b0;
        #1;
        chk("arst_bclk",  48'(bclk),             48'd0);
        chk("arst_lrclk", 48'(lrclk),            48'd0);
        chk("arst_sdata", 48'(sdata),            48'd0);
        chk("arst_und",   48'(underrun),         48'd0);
        chk("arst_ready", 48'(bus.sample_ready), 48'd1);
        en = 1'b0;
        tick();
        rstn = 1'b1;
        en = 1'b1;
        w = 0;
        while (w < 20 && underrun !== 1'b1) begin
            tick();
            w++;
        end
        chk("arst_first_load", 48'(w), 48'd4);

        // Enable drop mid-frame: link idles, held pair survives and leads the next frame.
        do_reset();
        en = 1'b1;
        repeat (5) tick();
        bus.sample_valid = 1'b1; {bus.sample_left, bus.sample_right} = 32'hC0DE_4321;
        tick();
        bus.sample_valid = 1'b0;
        for (int k = 0; k < 40 && en_t < 26; k++) tick();
        en = 1'b0;
        tick();
        chk("endrop_sdata", 48'(sdata),            48'd0);
        chk("endrop_ready", 48'(bus.sample_ready), 48'd0);
        repeat (3) tick();
        rx_q.delete();
        en = 1'b1;
        repeat (140) tick();
        chk("endrop_nrx", 48'(rx_q.size()), 48'd1);
        if (rx_q.size() > 0) chk("endrop_word", 48'(rx_q[0]), 48'h0000_C0DE_4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
Serialises signed PCM sample pairs, such as the 16-bit output of the sine generator, onto a Philips-I2S link with bclk, lrclk and sdata. It sits directly downstream of the sample source. It accepts one left/right pair per frame through a valid/ready handshake with a one-entry holding register, and generates all serial clocks from the system clock.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample (signed, two's complement, sent MSB first)
SLOT_WIDTH, 16, bclk periods per channel slot; must be >= SAMPLE_WIDTH; LSB side zero-padded
CLK_DIV, 4, clk cycles per bclk half-period; must be >= 1

Ports:
clk  input  1  system clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
enable  input  1  link enable; low = idle link, counters held at reset values
sample_valid  input  1  sample pair offered
sample_left  input  SAMPLE_WIDTH  left channel sample
sample_right  input  SAMPLE_WIDTH  right channel sample
sample_ready  output  1  holding register can accept a pair
bclk  output  1  serial bit clock
lrclk  output  1  word select; 0 = left, 1 = right
sdata  output  1  serial data, changes on bclk falling edge
underrun  output  1  one-clk pulse: frame started with no sample available

Behaviour:
- Reset (rstn low, async): bclk=0, lrclk=0, sdata=0, underrun=0, holding empty (sample_ready=1), div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, shifter=0.
- enable low: same state as reset, except holding register contents and its full flag are kept. Dropping enable mid-frame aborts the frame immediately; sdata=0 on the next clk.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1. At terminal count, bclk toggles. bclk period = 2*CLK_DIV clk cycles.
- Falling-edge event (bclk 1->0), all updates in the same clk:
  - bit_cnt advances modulo 2*SLOT_WIDTH.
  - sdata = next shifter bit.
  - lrclk = 1 when new bit_cnt is in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], else 0. lrclk therefore leads each slot's MSB by one bclk.
- Frame load: on the falling edge where bit_cnt wraps 2*SLOT_WIDTH-1 -> 0:
  - Shifter loaded with {left, zero pad, right, zero pad}.
  - Left MSB driven on sdata in that same clk; right MSB at bit_cnt=SLOT_WIDTH.
- First falling edge after enable rises comes 2*CLK_DIV clk cycles later and is a frame load. Frame length = 4*SLOT_WIDTH*CLK_DIV clk cycles.
- Handshake:
  - Transfer occurs when sample_valid & sample_ready.
  - sample_ready = !hold_full, combinational from the flag.
  - Transfer sets hold_full; frame load clears it.
  - Data must be held stable by the source only while valid & !ready.
- Bypass: if a frame load occurs while the holding register is empty and a transfer happens in the same clk:
  - The offered pair goes straight into the shifter.
  - hold_full stays 0.
  - No underrun.
- Simultaneous load with holding full: the holding register moves to the shifter and hold_full clears. A transfer cannot occur that clk because sample_ready=0.
- Underrun: frame load with holding empty and no transfer. Shifter is loaded with all zeros and underrun pulses high for exactly that clk.
- Sign: samples are transmitted raw; no sign extension or truncation inside the block.

Test Plan:
- Basic frame (CLK_DIV=2, SLOT=SAMPLE=16): enable=1, offer left=16'hA5F0, right=16'h0F0F before first load -> bits sampled on bclk rising edges = A5F0 then 0F0F MSB first; lrclk falls one bclk before bit 15 of A5F0; frame = 128 clk; underrun stays 0.
- Underrun: enable with no valid ever -> sdata constant 0; underrun pulses once per 128 clk, aligned to each frame load; sample_ready stays 1.
- Backpressure: hold valid with pairs P1, P2, P3 continuously -> P1 accepted at once; ready=0 until P1's frame load; P2 accepted within 1 clk of that load; P1, P2, P3 serialised in order with no duplicates or drops.
- Bypass: holding empty, assert valid with 16'h8001/16'h7FFE exactly on the load clk -> that pair is transmitted in the frame starting that clk; underrun=0; sample_ready remains 1 next clk.
- Padding (SLOT_WIDTH=24, SAMPLE_WIDTH=16): left=16'hFFFF -> 16 ones then 8 zeros per slot; frame = 192 clk at CLK_DIV=2.
- Mid-frame abort: deassert rstn (async) at bit_cnt=5 -> bclk, lrclk, sdata, underrun go 0 without waiting for a clk edge; after release and enable, the first load occurs 4 clk later (CLK_DIV=2) and the holding register is empty. Repeat with an enable drop instead of reset -> the held pair survives and is sent in the first frame.
